mul32_mac: RTL

- Iterative unsigned multiply-accumulate, p = a*b + c: 32x32 multiply plus 32-bit addend, 64-bit result.
- Inverse of the 64/32 divider. It rebuilds the dividend from the divider's quotient, divisor and remainder (x = q*d + r).
- Used as the divider's self-check path and as the general multiplier in the arithmetic unit.
- Processes RADIX_BITS multiplier bits per cycle. Valid/ready handshake on both input and output.

---
 rtl/mul32_mac.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mul32_mac.sv
// mul32_mac: iterative unsigned multiply-accumulate, p = a*b + c (32x32 + 32 -> 64).
// Retires RADIX_BITS multiplier bits per BUSY cycle; valid/ready handshake on input and output.
`default_nettype none

module mul32_mac #(
  parameter int RADIX_BITS = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] p
);

  localparam int STEPS = 32 / RADIX_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [63:0]      r_mcand;
  logic [31:0]      r_mplier;
  logic [63:0]      r_acc;
  logic [CNT_W-1:0] r_count;
  logic [63:0]      r_p;

  logic [63:0] w_pp;
  logic [63:0] w_acc_nxt;
  logic        w_last;

  // The multiplicand is kept pre-shifted by RADIX_BITS*count, so each step only
  // needs the small digit-times-multiplicand product, built from shifted adds.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (r_mplier[i]) begin
        w_pp = w_pp + (r_mcand << i);
      end
    end
  end

  assign w_acc_nxt = r_acc + w_pp;
  assign w_last    = (r_count == LAST_STEP);
  assign p         = r_p;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_p      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand  <= {32'b0, a};
            r_mplier <= b;
            r_acc    <= {32'b0, c};
            r_count  <= '0;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << RADIX_BITS;
          r_mplier <= r_mplier >> RADIX_BITS;
          r_count  <= r_count + CNT_W'(1);
          if (w_last) begin
            r_p <= w_acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
